// File: rtl/dbus_clint.sv
// dbus_clint: core-local interruptor target on the core data bus.
//   Holds the 64-bit mtime counter, the mtimecmp compare register and the msip
//   soft-interrupt bit, and drives the machine timer/software interrupt lines.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   addr_i     byte address from the LSU (bits [1:0] ignored)
//   arvalid_i  read request this cycle
//   wvalid_i   write request this cycle
//   wdata_i    lane-aligned write data
//   wstrb_i    byte write enables
//   rdata_o    read data, valid the cycle after arvalid_i, zero otherwise
//   mtip_o     machine timer interrupt pending (mtime >= mtimecmp)
//   msip_o     machine software interrupt pending
module dbus_clint #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN-1:0]   addr_i,
  input  logic              arvalid_i,
  input  logic              wvalid_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN/8-1:0] wstrb_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              mtip_o,
  output logic              msip_o
);

  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Word indices (byte offset / 4) of the mapped registers
  localparam logic [13:0] W_MSIP    = 14'h0000;
  localparam logic [13:0] W_CMP_LO  = 14'h1000;
  localparam logic [13:0] W_CMP_HI  = 14'h1001;
  localparam logic [13:0] W_TIME_LO = 14'h2FFE;
  localparam logic [13:0] W_TIME_HI = 14'h2FFF;

  logic [63:0]   mtime_q;
  logic [63:0]   mtime_inc;
  logic [63:0]   mtime_next;
  logic [63:0]   cmp_q;
  logic [63:0]   cmp_next;
  logic          msip_q;
  logic          msip_next;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_next;
  logic          tick;
  logic          sel;
  logic [13:0]   word;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   read_word;
  logic          unused_addr_bits;

  assign sel              = (addr_i[31:16] == BASE_ADDR[31:16]);
  assign word             = addr_i[15:2];
  assign wr_en            = sel && wvalid_i;
  assign rd_en            = sel && arvalid_i;
  assign unused_addr_bits = ^addr_i[1:0];

  // Replace only the byte lanes enabled in strb
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

  assign tick       = (presc_q == PRESC_MAX);
  assign presc_next = tick ? '0 : presc_q + PW'(1);
  assign mtime_inc  = mtime_q + {63'd0, tick};

  // Next-state for the registers. A bus write to an mtime half replaces the
  // incremented value only in the written lanes, so no carry crosses halves.
  always_comb begin
    mtime_next = mtime_inc;
    cmp_next   = cmp_q;
    msip_next  = msip_q;
    if (wr_en) begin
      case (word)
        W_MSIP:    if (wstrb_i[0]) msip_next = wdata_i[0];
        W_CMP_LO:  cmp_next[31:0]    = merge_lanes(cmp_q[31:0], wdata_i, wstrb_i);
        W_CMP_HI:  cmp_next[63:32]   = merge_lanes(cmp_q[63:32], wdata_i, wstrb_i);
        W_TIME_LO: mtime_next[31:0]  = merge_lanes(mtime_inc[31:0], wdata_i, wstrb_i);
        W_TIME_HI: mtime_next[63:32] = merge_lanes(mtime_inc[63:32], wdata_i, wstrb_i);
        default:   ;
      endcase
    end
  end

  // Read mux works on current register values, giving read-before-write order
  always_comb begin
    read_word = '0;
    case (word)
      W_MSIP:    read_word = {31'd0, msip_q};
      W_CMP_LO:  read_word = cmp_q[31:0];
      W_CMP_HI:  read_word = cmp_q[63:32];
      W_TIME_LO: read_word = mtime_q[31:0];
      W_TIME_HI: read_word = mtime_q[63:32];
      default:   read_word = '0;
    endcase
  end

  // Unselected cycles return zero so several targets can be OR-combined
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      msip_q  <= 1'b0;
      presc_q <= '0;
      rdata_o <= '0;
      mtip_o  <= 1'b0;
    end else begin
      mtime_q <= mtime_next;
      cmp_q   <= cmp_next;
      msip_q  <= msip_next;
      presc_q <= presc_next;
      rdata_o <= rd_en ? read_word : '0;
      mtip_o  <= (mtime_next >= cmp_next);
    end
  end

  assign msip_o = msip_q;

endmodule

// File: tb/tb_dbus_clint.sv
// Testbench for dbus_clint: two instances (TICK_DIV=1 and TICK_DIV=4) share
// one bus and are compared every cycle against a behavioural CLINT model,
// with directed scenarios followed by a randomized phase.
module tb_dbus_clint;

  logic        clk;
  logic        rstN;
  logic [31:0] addr;
  logic        arValid;
  logic        wValid;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic [31:0] rdataA, rdataB;
  logic        mtipA, mtipB, msipA, msipB;

  int checks = 0;
  int errors = 0;

  dbus_clint #(.XLEN(32), .BASE_ADDR(32'h0200_0000), .TICK_DIV(1)) dutA (
    .clk_i(clk), .rst_ni(rstN), .addr_i(addr), .arvalid_i(arValid),
    .wvalid_i(wValid), .wdata_i(wData), .wstrb_i(wStrb),
    .rdata_o(rdataA), .mtip_o(mtipA), .msip_o(msipA)
  );

  dbus_clint #(.XLEN(32), .BASE_ADDR(32'h0200_0000), .TICK_DIV(4)) dutB (
    .clk_i(clk), .rst_ni(rstN), .addr_i(addr), .arvalid_i(arValid),
    .wvalid_i(wValid), .wdata_i(wData), .wstrb_i(wStrb),
    .rdata_o(rdataB), .mtip_o(mtipB), .msip_o(msipB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of one CLINT: registers plus a count of clocked
  // cycles since reset; mtime advances whenever that count is a multiple
  // of the tick divider.
  typedef struct {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic        msip;
    int unsigned cyc;
    logic [31:0] rdata;
    logic        mtip;
  } model_t;

  model_t      m[2];
  int unsigned tickDiv[2] = '{1, 4};

  function automatic logic [31:0] laneMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{strb[b]}};
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

  function automatic logic [31:0] readReg(input int i, input logic [31:0] a);
    logic [15:0] off;
    if (a[31:16] != 16'h0200) return 32'd0;
    off = {a[15:2], 2'b00};
    case (off)
      16'h0000: return {31'd0, m[i].msip};
      16'h4000: return m[i].cmp[31:0];
      16'h4004: return m[i].cmp[63:32];
      16'hBFF8: return m[i].mtime[31:0];
      16'hBFFC: return m[i].mtime[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic modelStep(input int i);
    logic [63:0] nt;
    logic [31:0] rd;
    logic [15:0] off;
    logic        hit;
    if (!rstN) begin
      m[i].mtime = 64'd0;
      m[i].cmp   = '1;
      m[i].msip  = 1'b0;
      m[i].cyc   = 0;
      m[i].rdata = 32'd0;
      m[i].mtip  = 1'b0;
    end else begin
      hit = (addr[31:16] == 16'h0200);
      off = {addr[15:2], 2'b00};
      rd  = arValid ? readReg(i, addr) : 32'd0;
      m[i].cyc = m[i].cyc + 1;
      nt = m[i].mtime + (((m[i].cyc % tickDiv[i]) == 0) ? 64'd1 : 64'd0);
      if (wValid && hit) begin
        case (off)
          16'h0000: if (wStrb[0]) m[i].msip = wData[0];
          16'h4000: m[i].cmp[31:0]  = laneMerge(m[i].cmp[31:0], wData, wStrb);
          16'h4004: m[i].cmp[63:32] = laneMerge(m[i].cmp[63:32], wData, wStrb);
          16'hBFF8: nt[31:0]        = laneMerge(nt[31:0], wData, wStrb);
          16'hBFFC: nt[63:32]       = laneMerge(nt[63:32], wData, wStrb);
          default:  ;
        endcase
      end
      m[i].mtime = nt;
      m[i].mtip  = (m[i].mtime >= m[i].cmp);
      m[i].rdata = rd;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs, clock, advance model, compare all outputs
  task automatic applyStimulus(input logic r, input logic [31:0] a,
                               input logic ar, input logic wv,
                               input logic [31:0] wd, input logic [3:0] ws);
    rstN    = r;
    addr    = a;
    arValid = ar;
    wValid  = wv;
    wData   = wd;
    wStrb   = ws;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput("rdata_a", 64'(rdataA), 64'(m[0].rdata));
    checkOutput("mtip_a",  64'(mtipA),  64'(m[0].mtip));
    checkOutput("msip_a",  64'(msipA),  64'(m[0].msip));
    checkOutput("rdata_b", 64'(rdataB), 64'(m[1].rdata));
    checkOutput("mtip_b",  64'(mtipB),  64'(m[1].mtip));
    checkOutput("msip_b",  64'(msipB),  64'(m[1].msip));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    applyStimulus(1'b1, a, 1'b0, 1'b1, d, s);
  endtask

  task automatic busRead(input logic [31:0] a);
    applyStimulus(1'b1, a, 1'b1, 1'b0, 32'd0, 4'h0);
  endtask

  task automatic doReset(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0);
  endtask

  logic [31:0] addrList[7] = '{32'h0200_0000, 32'h0200_4000, 32'h0200_4004,
                               32'h0200_BFF8, 32'h0200_BFFC, 32'h0200_0010,
                               32'h0300_4000};

  initial begin
    int riseEdge;
    logic [31:0] ra;
    logic [31:0] rd;

    rstN = 1'b0; addr = '0; arValid = 1'b0; wValid = 1'b0; wData = '0; wStrb = '0;

    // Reset state and mtimecmp reset value
    doReset(3);
    checkOutput("t1_rdata", 64'(rdataA), 64'd0);
    checkOutput("t1_mtip",  64'(mtipA),  64'd0);
    checkOutput("t1_msip",  64'(msipA),  64'd0);
    busRead(32'h0200_4004);
    checkOutput("t1_cmp_hi", 64'(rdataA), 64'h0000_0000_FFFF_FFFF);

    // Prescaled count: 40 cycles after release
    doReset(2);
    idle(40);
    busRead(32'h0200_BFF8);
    checkOutput("t2_count_div4", 64'(rdataB), 64'd10);
    checkOutput("t2_count_div1", 64'(rdataA), 64'd40);

    // Timer interrupt rise and fall
    doReset(2);
    busWrite(32'h0200_4000, 32'd20, 4'hF);
    busWrite(32'h0200_4004, 32'd0, 4'hF);
    checkOutput("t3_mtip_low", 64'(mtipA), 64'd0);
    riseEdge = -1;
    for (int n = 3; n <= 25; n++) begin
      idle(1);
      if (mtipA && riseEdge < 0) riseEdge = n;
    end
    checkOutput("t3_rise_edge", 64'(riseEdge), 64'd20);
    busWrite(32'h0200_4004, 32'd1, 4'hF);
    checkOutput("t3_mtip_fall", 64'(mtipA), 64'd0);

    // Byte strobes on msip
    busWrite(32'h0200_0000, 32'd1, 4'b0010);
    checkOutput("t4_msip_lane1", 64'(msipA), 64'd0);
    busWrite(32'h0200_0000, 32'd1, 4'b0001);
    checkOutput("t4_msip_lane0", 64'(msipA), 64'd1);
    busRead(32'h0200_0000);
    checkOutput("t4_msip_read", 64'(rdataA), 64'd1);

    // mtime wrap through all-ones
    busWrite(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF);
    busWrite(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
    checkOutput("t5_mtip_ones", 64'(mtipA), 64'd1);
    idle(1);
    checkOutput("t5_mtip_wrap", 64'(mtipA), 64'd0);
    busRead(32'h0200_BFF8);
    checkOutput("t5_time_lo", 64'(rdataA), 64'd0);
    busRead(32'h0200_BFFC);
    checkOutput("t5_time_hi", 64'(rdataA), 64'd0);

    // Miss, read-before-write, reset discarding a read
    busRead(32'h0200_4000);
    checkOutput("t6_cmp_lo", 64'(rdataA), 64'd20);
    busRead(32'h1234_0000);
    checkOutput("t6_miss", 64'(rdataA), 64'd0);
    applyStimulus(1'b1, 32'h0200_4000, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF);
    checkOutput("t6_raw_old", 64'(rdataA), 64'd20);
    busRead(32'h0200_4000);
    checkOutput("t6_raw_new", 64'(rdataA), 64'h0000_0000_DEAD_BEEF);
    applyStimulus(1'b0, 32'h0200_4000, 1'b1, 1'b0, 32'd0, 4'h0);
    checkOutput("t6_rst_rdata", 64'(rdataA), 64'd0);
    checkOutput("t6_rst_msip",  64'(msipA),  64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      ra = addrList[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
      rd = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      applyStimulus(($urandom_range(0, 63) != 0), ra, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), rd, 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
